hpi_responder: RTL
==================

Name: hpi_responder

Overview:
- Device-side (responder) end of the 16-bit OTG host-port interface (HPI) that the SoC drives through its cs/r/w/reset/address/data PIO exports.
- Decodes host strobes into four registers: DATA, MAILBOX, ADDRESS and STATUS.
- Backs DATA with an internal word RAM that auto-increments the address on every access, and provides a two-way mailbox to device-side logic.
- Used as an on-FPGA stand-in for the USB controller and as the bench responder for the HPI driver software.

Parameters:
- MEM_WORDS, 256, depth of the internal 16-bit RAM; power of two.
- MEM_AW, 8, log2(MEM_WORDS); word index width.

Ports:
- clk_clk  in  1  system clock; all HPI inputs are synchronous to it.
- reset_reset_n  in  1  asynchronous active-low reset.
- hpi_reset_n  in  1  host soft reset, active low, sampled synchronously.
- hpi_cs_n  in  1  chip select, active low.
- hpi_r_n  in  1  read strobe, active low.
- hpi_w_n  in  1  write strobe, active low.
- hpi_addr  in  2  register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS.
- hpi_data_in  in  16  host write data.
- hpi_data_out  out  16  read data returned to the host.
- hpi_data_oe  out  1  high while the responder drives the data bus.
- hpi_int  out  1  interrupt to host = mbx_out_full.
- dev_mbx_in_data  out  16  last host-written mailbox word.
- dev_mbx_in_valid  out  1  host mailbox word pending.
- dev_mbx_in_ack  in  1  one-cycle pulse; clears dev_mbx_in_valid.
- dev_mbx_post  in  1  one-cycle pulse; posts dev_mbx_post_data to the host.
- dev_mbx_post_data  in  16  device-to-host mailbox word.
- dev_rd_addr  in  MEM_AW  device-side RAM read index.
- dev_rd_data  out  16  RAM word at dev_rd_addr, one-cycle latency.

Behaviour:
- Reset values (async reset, or hpi_reset_n low at a clock edge): hpi_data_out=0, hpi_data_oe=0, address register=0, mailbox registers=0, all flags=0, hpi_int=0, dev_rd_data=0. RAM contents are not cleared.
- Strobe detection: the registered previous values of hpi_r_n and hpi_w_n are initialised to 1 on reset.
  - A read access is the first cycle with cs_n=0 and r_n=0 where the previous r_n was 1.
  - A write access is defined the same way on w_n.
  - Each strobe assertion produces exactly one access, regardless of its length.
- If r_n and w_n are both low with cs_n low, the cycle is a protocol error: no access occurs and STATUS bit3 (err) is set.
- Strobes with cs_n=1 are ignored.
- Write access, committed on the detect cycle:
  - DATA: RAM[addr[MEM_AW:1]] <= data_in, then addr <= addr+2.
  - MAILBOX: mbx_in <= data_in and mbx_in_full <= 1. If mbx_in_full was already 1, also set STATUS bit2 (overrun).
  - ADDRESS: addr <= data_in. Bit0 is stored but ignored for RAM indexing.
  - STATUS: write is ignored.
- Read access:
  - hpi_data_out is registered and valid on the cycle after detect. It holds until the next read access.
  - hpi_data_oe = registered (cs_n=0 & r_n=0 & w_n=1). It therefore rises one cycle after detect and falls one cycle after r_n rises.
  - DATA: returns RAM[addr index], then addr <= addr+2.
  - MAILBOX: returns mbx_out and clears mbx_out_full.
  - ADDRESS: returns addr.
  - STATUS: returns {12'b0, err, overrun, mbx_in_full, mbx_out_full}, then clears err and overrun. The returned value is the pre-clear value.
- Address wrap: addr is 16 bits and wraps 0xFFFE+2 to 0x0000. The RAM index is addr[MEM_AW:1], so it aliases modulo MEM_WORDS.
- Device mailbox:
  - dev_mbx_post latches mbx_out and sets mbx_out_full; a post while already full overwrites the word.
  - dev_mbx_in_ack clears mbx_in_full.
  - dev_mbx_in_valid = mbx_in_full; dev_mbx_in_data = mbx_in.
- Same-cycle conflicts:
  - A post coincides with a host MAILBOX read: the read returns the old mbx_out; the new word is latched and mbx_out_full stays 1.
  - An ack coincides with a host MAILBOX write: the write wins and mbx_in_full stays 1.
  - A host DATA write coincides with a device read of the same index: dev_rd_data returns the old word (read-before-write).
- No write-to-read forwarding is required beyond this. Back-to-back accesses need at least one idle strobe cycle between them.

Test Plan:
- Host writes ADDRESS=0x0010, then writes DATA 0xAAAA, 0x5555 -> RAM[8]=0xAAAA, RAM[9]=0x5555; ADDRESS reads back 0x0014.
- Host writes ADDRESS=0x0010, then reads DATA twice -> data_out=0xAAAA then 0x5555, each one cycle after r_n falls; oe high only during the strobes; a 5-cycle-long r_n yields a single increment.
- Host writes ADDRESS=0xFFFE, then writes DATA 0x1234 -> RAM[MEM_WORDS-1]=0x1234; ADDRESS reads 0x0000.
- Host writes MAILBOX 0x0051 twice without ack -> dev_mbx_in_valid=1, data=0x0051, STATUS reads 0x0006 then 0x0002. After ack, STATUS reads 0x0000.
- dev_mbx_post 0xBEEF -> hpi_int=1, STATUS=0x0001. A host MAILBOX read returns 0xBEEF and hpi_int drops. Post 0xCAFE on the same cycle as the read detect -> the read returns 0xBEEF and hpi_int stays 1.
- Assert r_n and w_n together with cs_n low -> no RAM change, STATUS bit3=1. Pull reset_reset_n low mid-strobe -> all outputs 0 asynchronously and RAM is retained; hpi_reset_n low for one cycle gives the same register clear.

Source files
------------

// File: rtl/hpi_responder.sv
`timescale 1ns/1ps
// hpi_responder
//   Device-side end of the 16-bit OTG host-port interface. The host selects
//   one of four registers (DATA, MAILBOX, ADDRESS, STATUS) with hpi_addr and
//   issues one access per falling edge of hpi_r_n / hpi_w_n while hpi_cs_n is
//   low. DATA is backed by an internal word RAM indexed by the auto-
//   incrementing byte address register. A two-entry mailbox (host->device and
//   device->host) links the host to device-side logic.
//
// Ports
//   clk_clk            system clock; every HPI input is synchronous to it
//   reset_reset_n      asynchronous active-low reset
//   hpi_reset_n        host soft reset, active low, sampled on the clock
//   hpi_cs_n/r_n/w_n   active-low chip select, read and write strobes
//   hpi_addr           register select 0=DATA 1=MAILBOX 2=ADDRESS 3=STATUS
//   hpi_data_in        host write data
//   hpi_data_out       registered read data, held until the next read
//   hpi_data_oe        high while the responder drives the host bus
//   hpi_int            interrupt to host, high while a device word waits
//   dev_mbx_in_*       host-to-device mailbox word, pending flag and ack
//   dev_mbx_post*      device-to-host mailbox post pulse and word
//   dev_rd_addr/data   device-side RAM read port, one-cycle latency
module hpi_responder #(
  parameter int MEM_WORDS = 256,
  parameter int MEM_AW    = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              hpi_reset_n,
  input  logic              hpi_cs_n,
  input  logic              hpi_r_n,
  input  logic              hpi_w_n,
  input  logic [1:0]        hpi_addr,
  input  logic [15:0]       hpi_data_in,
  output logic [15:0]       hpi_data_out,
  output logic              hpi_data_oe,
  output logic              hpi_int,
  output logic [15:0]       dev_mbx_in_data,
  output logic              dev_mbx_in_valid,
  input  logic              dev_mbx_in_ack,
  input  logic              dev_mbx_post,
  input  logic [15:0]       dev_mbx_post_data,
  input  logic [MEM_AW-1:0] dev_rd_addr,
  output logic [15:0]       dev_rd_data
);

  localparam int DATA_W = 16;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MBX  = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  logic [DATA_W-1:0] ram [MEM_WORDS];

  logic              r_prev_p1;
  logic              w_prev_p1;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] mbx_in;
  logic [DATA_W-1:0] mbx_out;
  logic              mbx_in_full;
  logic              mbx_out_full;
  logic              overrun;
  logic              err;

  logic              sel;
  logic              both_low;
  logic              rd_acc;
  logic              wr_acc;
  logic [MEM_AW-1:0] idx;
  logic [DATA_W-1:0] status;
  logic [DATA_W-1:0] rd_mux;

  // Access detection: a strobe counts only on its first low cycle, and a
  // cycle with both strobes low is an error rather than an access.
  assign sel      = ~hpi_cs_n;
  assign both_low = sel & ~hpi_r_n & ~hpi_w_n;
  assign rd_acc   = sel & ~hpi_r_n & r_prev_p1 & hpi_w_n;
  assign wr_acc   = sel & ~hpi_w_n & w_prev_p1 & hpi_r_n;

  // Bit0 of the byte address is kept for read-back but never selects a word.
  assign idx    = addr[MEM_AW:1];
  assign status = {12'b0, err, overrun, mbx_in_full, mbx_out_full};

  assign hpi_int          = mbx_out_full;
  assign dev_mbx_in_valid = mbx_in_full;
  assign dev_mbx_in_data  = mbx_in;

  always_comb begin
    rd_mux = '0;
    case (hpi_addr)
      REG_DATA: rd_mux = ram[idx];
      REG_MBX:  rd_mux = mbx_out;
      REG_ADDR: rd_mux = addr;
      REG_STAT: rd_mux = status;
      default:  rd_mux = '0;
    endcase
  end

  // RAM storage has no reset so contents survive both reset sources.
  always_ff @(posedge clk_clk) begin
    if (reset_reset_n && hpi_reset_n && wr_acc && (hpi_addr == REG_DATA))
      ram[idx] <= hpi_data_in;
  end

  // Register stage: control, mailbox and read-return state
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_prev_p1    <= 1'b1;
      w_prev_p1    <= 1'b1;
      addr         <= '0;
      mbx_in       <= '0;
      mbx_out      <= '0;
      mbx_in_full  <= 1'b0;
      mbx_out_full <= 1'b0;
      overrun      <= 1'b0;
      err          <= 1'b0;
      hpi_data_out <= '0;
      hpi_data_oe  <= 1'b0;
      dev_rd_data  <= '0;
    end else if (!hpi_reset_n) begin
      r_prev_p1    <= 1'b1;
      w_prev_p1    <= 1'b1;
      addr         <= '0;
      mbx_in       <= '0;
      mbx_out      <= '0;
      mbx_in_full  <= 1'b0;
      mbx_out_full <= 1'b0;
      overrun      <= 1'b0;
      err          <= 1'b0;
      hpi_data_out <= '0;
      hpi_data_oe  <= 1'b0;
      dev_rd_data  <= '0;
    end else begin
      r_prev_p1   <= hpi_r_n;
      w_prev_p1   <= hpi_w_n;
      hpi_data_oe <= sel & ~hpi_r_n & hpi_w_n;
      // Old word is captured even when the host writes the same index now.
      dev_rd_data <= ram[dev_rd_addr];

      if (both_low)
        err <= 1'b1;

      // Ack is applied before the host write so a coincident write keeps
      // the mailbox full.
      if (dev_mbx_in_ack)
        mbx_in_full <= 1'b0;

      if (wr_acc) begin
        case (hpi_addr)
          REG_DATA: addr <= addr + 16'd2;
          REG_MBX: begin
            mbx_in      <= hpi_data_in;
            mbx_in_full <= 1'b1;
            if (mbx_in_full)
              overrun <= 1'b1;
          end
          REG_ADDR: addr <= hpi_data_in;
          default: ;
        endcase
      end

      if (rd_acc) begin
        hpi_data_out <= rd_mux;
        case (hpi_addr)
          REG_DATA: addr <= addr + 16'd2;
          REG_MBX:  mbx_out_full <= 1'b0;
          REG_STAT: begin
            err     <= 1'b0;
            overrun <= 1'b0;
          end
          default: ;
        endcase
      end

      // Post is applied after the host read so a coincident post leaves the
      // new word pending while the read returns the old one.
      if (dev_mbx_post) begin
        mbx_out      <= dev_mbx_post_data;
        mbx_out_full <= 1'b1;
      end
    end
  end

endmodule
